// File: rtl/pipe_stage_buf_pkg.sv
// rtl/pipe_stage_buf_pkg.sv - shared defaults and helpers for the elastic stage buffer
package pipe_stage_buf_pkg;

  localparam int unsigned PIPE_DATA_W = 72;
  localparam int unsigned PIPE_DEPTH  = 2;

  typedef struct packed {
    logic push;
    logic pop;
  } xfer_t;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipe_buf_ram.sv
// rtl/pipe_buf_ram.sv - DEPTH x DATA_W register array, one write port, one async read port
module pipe_buf_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - elastic DEPTH-entry pipeline register with valid/ready and flush
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int unsigned       DATA_W    = PIPE_DATA_W,
  parameter int unsigned       DEPTH     = PIPE_DEPTH,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0,
  localparam int unsigned      CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  occupancy
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] head_data;
  xfer_t             xfer;

  // in_ready depends only on the registered count, so out_ready never reaches upstream.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? head_data : NOP_VALUE;
  assign occupancy = count_q;

  always_comb begin
    xfer.push = in_valid & in_ready;
    xfer.pop  = out_valid & out_ready;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (xfer.push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (xfer.pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(xfer.push) - CNT_W'(xfer.pop);
    end
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  pipe_buf_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clk   (cpu_clk_50M),
    .we    (xfer.push & ~flush & ~cpu_rst),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .raddr (rd_ptr_q),
    .rdata (head_data)
  );

  a_occ_bound: assert property (@(posedge cpu_clk_50M) disable iff (cpu_rst)
    count_q <= CNT_W'(DEPTH));
  a_no_push_full: assert property (@(posedge cpu_clk_50M) disable iff (cpu_rst)
    !(xfer.push && (count_q == CNT_W'(DEPTH))));
  a_no_pop_empty: assert property (@(posedge cpu_clk_50M) disable iff (cpu_rst)
    !(xfer.pop && (count_q == '0)));

endmodule
